// File: rtl/button_conditioner.sv
// Pushbutton front end: per-input 2-flop sync + debounce, frame-latched movement, rate-limited fire pulse.
// Define BUTTON_AUTOFIRE_EN to re-arm fire automatically at the end of cooldown while the button is held.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES      = 742500,
    parameter int FIRE_COOLDOWN_FRAMES = 8
) (
    input  logic pixel_clk,
    input  logic rst,
    input  logic fsync,
    input  logic right_raw,
    input  logic left_raw,
    input  logic fire_raw,
    output logic right_db,
    output logic left_db,
    output logic fire_db,
    output logic move_right,
    output logic move_left,
    output logic fire_pulse,
    output logic fire_busy
);
    localparam int NIN = 3;
    localparam int CW  = $clog2(DEBOUNCE_CYCLES);
    localparam int FW  = $clog2(FIRE_COOLDOWN_FRAMES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [FW-1:0] CD_LOAD  = FW'(FIRE_COOLDOWN_FRAMES);
    localparam logic [FW-1:0] CD_ONE   = FW'(1);

    typedef enum logic [1:0] {IDLE, ARMED, COOLDOWN, WAIT_RELEASE} fire_state_e;

    logic [NIN-1:0] raw;
    logic [NIN-1:0] db;

    assign raw = {fire_raw, left_raw, right_raw};

    for (genvar g = 0; g < NIN; g++) begin : g_in
        logic          sync1_q, sync2_q;
        logic          stable_q, stable_d;
        logic [CW-1:0] cnt_q, cnt_d;

        // Counter only runs while the synchronized level disagrees with the stable one.
        always_comb begin
            cnt_d    = '0;
            stable_d = stable_q;
            if (sync2_q != stable_q) begin
                if (cnt_q == CNT_LAST) stable_d = ~stable_q;
                else                   cnt_d    = cnt_q + 1'b1;
            end
        end

        always_ff @(posedge pixel_clk) begin
            if (rst) begin
                sync1_q  <= 1'b0;
                sync2_q  <= 1'b0;
                stable_q <= 1'b0;
                cnt_q    <= '0;
            end else begin
                sync1_q  <= raw[g];
                sync2_q  <= sync1_q;
                stable_q <= stable_d;
                cnt_q    <= cnt_d;
            end
        end

        assign db[g] = stable_q;
    end

    assign right_db = db[0];
    assign left_db  = db[1];
    assign fire_db  = db[2];

    logic move_right_q, move_left_q;

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            move_right_q <= 1'b0;
            move_left_q  <= 1'b0;
        end else if (fsync) begin
            move_right_q <= db[0] & ~db[1];
            move_left_q  <= db[1] & ~db[0];
        end
    end

    assign move_right = move_right_q;
    assign move_left  = move_left_q;

    fire_state_e   state_q;
    logic [FW-1:0] cd_q;
    logic          fire_db_d_q, fire_pulse_q, fire_busy_q;
    logic          fire_rise;

    assign fire_rise = db[2] & ~fire_db_d_q;

    // Presses outside IDLE are dropped; a press coinciding with fsync still waits a full frame.
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cd_q         <= '0;
            fire_db_d_q  <= 1'b0;
            fire_pulse_q <= 1'b0;
            fire_busy_q  <= 1'b0;
        end else begin
            fire_db_d_q  <= db[2];
            fire_pulse_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (fire_rise) begin
                        state_q     <= ARMED;
                        fire_busy_q <= 1'b1;
                    end
                end
                ARMED: begin
                    if (fsync) begin
                        fire_pulse_q <= 1'b1;
                        cd_q         <= CD_LOAD;
                        state_q      <= COOLDOWN;
                    end
                end
                COOLDOWN: begin
                    if (fsync) begin
                        cd_q <= cd_q - 1'b1;
                        if (cd_q == CD_ONE) begin
`ifdef BUTTON_AUTOFIRE_EN
                            state_q <= db[2] ? ARMED : WAIT_RELEASE;
`else
                            state_q <= WAIT_RELEASE;
`endif
                        end
                    end
                end
                WAIT_RELEASE: begin
                    if (!db[2]) begin
                        state_q     <= IDLE;
                        fire_busy_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    fire_busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign fire_pulse = fire_pulse_q;
    assign fire_busy  = fire_busy_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Event scoreboard for button_conditioner: stimulus queues expected output transitions
// (cycle, signal, value); a negedge monitor matches every observed output change against the queue.
module tb_button_conditioner;
    localparam int DB = 4;
    localparam int CD = 2;

    logic pixel_clk = 1'b0;
    logic rst       = 1'b1;
    logic fsync     = 1'b0;
    logic right_raw = 1'b1;
    logic left_raw  = 1'b1;
    logic fire_raw  = 1'b1;
    logic right_db, left_db, fire_db, move_right, move_left, fire_pulse, fire_busy;

    int cyc    = 0;
    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        int c;
        int id;
        bit v;
    } ev_t;

    ev_t        expq[$];
    logic [6:0] obs, prev_obs;

    localparam int RDB = 0, LDB = 1, FDB = 2, MR = 3, ML = 4, FP = 5, FB = 6;

    button_conditioner #(
        .DEBOUNCE_CYCLES     (DB),
        .FIRE_COOLDOWN_FRAMES(CD)
    ) dut (
        .pixel_clk (pixel_clk),
        .rst       (rst),
        .fsync     (fsync),
        .right_raw (right_raw),
        .left_raw  (left_raw),
        .fire_raw  (fire_raw),
        .right_db  (right_db),
        .left_db   (left_db),
        .fire_db   (fire_db),
        .move_right(move_right),
        .move_left (move_left),
        .fire_pulse(fire_pulse),
        .fire_busy (fire_busy)
    );

    always #5 pixel_clk = ~pixel_clk;
    always @(posedge pixel_clk) cyc <= cyc + 1;

    function automatic string nm(input int id);
        case (id)
            RDB: return "right_db";
            LDB: return "left_db";
            FDB: return "fire_db";
            MR:  return "move_right";
            ML:  return "move_left";
            FP:  return "fire_pulse";
            default: return "fire_busy";
        endcase
    endfunction

    task automatic ex(input int c, input int id, input bit v);
        ev_t e;
        e.c = c; e.id = id; e.v = v;
        expq.push_back(e);
    endtask

    task automatic goto(input int c);
        while (cyc < c) @(negedge pixel_clk);
    endtask

    // fsync sampled high on every edge whose index is a multiple of 50
    initial forever begin
        @(negedge pixel_clk);
        fsync = ((cyc + 1) % 50 == 0);
    end

    initial begin
        prev_obs = '0;
        forever begin
            @(negedge pixel_clk);
            obs = {fire_busy, fire_pulse, move_left, move_right, fire_db, left_db, right_db};
            for (int i = 0; i < 7; i++) begin
                if (obs[i] !== prev_obs[i]) begin
                    int k;
                    k = -1;
                    n_chk++;
                    foreach (expq[j])
                        if (k < 0 && expq[j].c == cyc && expq[j].id == i && expq[j].v == obs[i]) k = j;
                    if (k >= 0) expq.delete(k);
                    else begin
                        n_fail++;
                        $display("FAIL %s at cycle %0d: changed to %b, required to hold %b", nm(i), cyc, obs[i], prev_obs[i]);
                    end
                end
            end
            prev_obs = obs;
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: test did not complete, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        // reset with all buttons held: they appear as fresh presses after debounce
        ex(9, RDB, 1); ex(9, LDB, 1); ex(9, FDB, 1);
        ex(10, FB, 1);
        ex(15, RDB, 0); ex(15, LDB, 0); ex(15, FDB, 0);
        ex(50, FP, 1); ex(51, FP, 0);
        ex(151, FB, 0);

        goto(2);
        obs = {fire_busy, fire_pulse, move_left, move_right, fire_db, left_db, right_db};
        for (int i = 0; i < 7; i++) begin
            n_chk++;
            if (obs[i] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_%s: got %b, required 0", nm(i), obs[i]);
            end
        end
        goto(3); rst = 1'b0;
        goto(9); right_raw = 1'b0; left_raw = 1'b0; fire_raw = 1'b0;

        // glitch of 3 cycles rejected, then a clean press
        goto(20); right_raw = 1'b1;
        goto(23); right_raw = 1'b0;
        goto(30); right_raw = 1'b1;
        ex(36, RDB, 1); ex(50, MR, 1);
        goto(60); left_raw = 1'b1;
        ex(66, LDB, 1); ex(100, MR, 0);
        goto(110); right_raw = 1'b0;
        ex(116, RDB, 0); ex(150, ML, 1);
        goto(160); left_raw = 1'b0;
        ex(166, LDB, 0); ex(200, ML, 0);

        // fire held for 400 cycles
        goto(210); fire_raw = 1'b1;
        ex(216, FDB, 1); ex(217, FB, 1); ex(250, FP, 1); ex(251, FP, 0);
`ifdef BUTTON_AUTOFIRE_EN
        ex(400, FP, 1); ex(401, FP, 0); ex(550, FP, 1); ex(551, FP, 0);
        ex(616, FDB, 0); ex(651, FB, 0);
`else
        ex(616, FDB, 0); ex(617, FB, 0);
`endif
        goto(610); fire_raw = 1'b0;

        // re-press during cooldown is discarded; press after busy clears fires again
        goto(700); fire_raw = 1'b1;
        ex(706, FDB, 1); ex(707, FB, 1); ex(750, FP, 1); ex(751, FP, 0);
        goto(760); fire_raw = 1'b0;
        ex(766, FDB, 0);
        goto(780); fire_raw = 1'b1;
        ex(786, FDB, 1);
        goto(820); fire_raw = 1'b0;
        ex(826, FDB, 0); ex(851, FB, 0);
        goto(870); fire_raw = 1'b1;
        ex(876, FDB, 1); ex(877, FB, 1); ex(900, FP, 1); ex(901, FP, 0);
        goto(910); fire_raw = 1'b0;
        ex(916, FDB, 0); ex(1001, FB, 0);

        // reset during cooldown aborts it at once
        goto(1020); fire_raw = 1'b1;
        ex(1026, FDB, 1); ex(1027, FB, 1); ex(1050, FP, 1); ex(1051, FP, 0);
        goto(1060); fire_raw = 1'b0;
        ex(1066, FDB, 0);
        goto(1070); rst = 1'b1;
        ex(1071, FB, 0);
        goto(1072); rst = 1'b0;

        goto(1130);
        foreach (expq[j]) begin
            n_chk++;
            n_fail++;
            $display("FAIL missing %s at cycle %0d: no transition seen, required change to %b", nm(expq[j].id), expq[j].c, expq[j].v);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
